// File: rtl/led_pattern_scheduler.sv
// Fixed-priority owner of the 4-bit LED bank, stepping on a self-generated tick; walking-one when idle.
// Optional blinking of the owner pattern: define LED_PATTERN_SCHEDULER_BLINK_EN.
module led_pattern_scheduler #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int STEP_HZ        = 2,
  parameter int MIN_HOLD_STEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [11:0] req_pat,
  output logic [2:0]  gnt,
  output logic [3:0]  led,
  output logic        step_tick
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW  = (MIN_HOLD_STEPS > 1) ? $clog2(MIN_HOLD_STEPS) : 1;
  localparam logic [PW-1:0] CNT_MAX  = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD_STEPS - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [3:0]      led_q, led_d;
  logic [3:0]      latch_q, latch_d;
  logic [1:0]      walk_q, walk_d;
  logic [HW-1:0]   hold_q, hold_d;
`ifdef LED_PATTERN_SCHEDULER_BLINK_EN
  logic            phase_q, phase_d;
`endif

  logic [1:0] win_idx, own_idx;
  logic [2:0] win_oh;
  logic [3:0] win_pat, own_pat;
  logic       req_any, own_req, higher_req, hold_met, go_idle, regrant;

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == CNT_MAX);
  end

  // Lowest-indexed request wins; the owner index is recovered from the one-hot grant.
  always_comb begin
    win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    own_idx = gnt_q[1] ? 2'd1 : (gnt_q[2] ? 2'd2 : 2'd0);
  end

  assign win_oh     = 3'b001 << win_idx;
  assign win_pat    = req_pat[win_idx*4 +: 4];
  assign own_pat    = req_pat[own_idx*4 +: 4];
  assign req_any    = |req;
  assign own_req    = |(req & gnt_q);
  assign higher_req = |(req & (gnt_q - 3'd1));
  assign hold_met   = (hold_q >= HOLD_MAX);
  assign go_idle    = hold_met && !req_any;
  assign regrant    = hold_met && req_any && (!own_req || higher_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick_q) begin
      case (state_q)
        IDLE:    if (req_any) state_d = OWN;
        OWN:     if (go_idle) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    gnt_d   = gnt_q;
    led_d   = led_q;
    latch_d = latch_q;
    walk_d  = walk_q;
    hold_d  = hold_q;
`ifdef LED_PATTERN_SCHEDULER_BLINK_EN
    phase_d = phase_q;
`endif
    if (tick_q) begin
      if (state_q == IDLE && !req_any) begin
        led_d  = 4'b0001 << walk_q;
        walk_d = walk_q + 2'd1;
      end else if ((state_q == IDLE) || regrant) begin
        gnt_d   = win_oh;
        latch_d = win_pat;
        led_d   = win_pat;
        hold_d  = '0;
`ifdef LED_PATTERN_SCHEDULER_BLINK_EN
        phase_d = 1'b1;
`endif
      end else if (go_idle) begin
        gnt_d  = 3'b000;
        walk_d = 2'd1;
        led_d  = 4'b0001;
      end else begin
        // Staying owner: pattern tracks the live request, frozen once it is dropped.
        if (!hold_met) hold_d = hold_q + 1'b1;
        if (own_req)   latch_d = own_pat;
`ifdef LED_PATTERN_SCHEDULER_BLINK_EN
        phase_d = ~phase_q;
        led_d   = phase_d ? latch_d : 4'b0000;
`else
        led_d   = latch_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      gnt_q   <= 3'b000;
      led_q   <= 4'b0000;
      latch_q <= 4'b0000;
      walk_q  <= 2'd0;
      hold_q  <= '0;
`ifdef LED_PATTERN_SCHEDULER_BLINK_EN
      phase_q <= 1'b1;
`endif
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      latch_q <= latch_d;
      walk_q  <= walk_d;
      hold_q  <= hold_d;
`ifdef LED_PATTERN_SCHEDULER_BLINK_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign led       = led_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench for led_pattern_scheduler at DIV=4, MIN_HOLD_STEPS=2; blink expectations follow LED_PATTERN_SCHEDULER_BLINK_EN.
module tb_led_pattern_scheduler;

`ifdef LED_PATTERN_SCHEDULER_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] req_pat;
  logic [2:0]  gnt;
  logic [3:0]  led;
  logic        step_tick;

  int vectors     = 0;
  int miscompares = 0;
  int tick_no     = 0;
  logic [6:0] sb_q[$];

  led_pattern_scheduler #(
    .CLK_HZ(8), .STEP_HZ(2), .MIN_HOLD_STEPS(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_pat(req_pat),
    .gnt(gnt), .led(led), .step_tick(step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one vector for the next tick edge and queue the outputs that edge must produce.
  task automatic step(input logic [2:0] r, input logic [11:0] p,
                      input logic [2:0] eg, input logic [3:0] el);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_tick && n < 12);
    if (!step_tick) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: got no step_tick within %0d cycles, expected one within 4", n);
    end else begin
      req     = r;
      req_pat = p;
      sb_q.push_back({eg, el});
    end
  endtask

  // Monitor: compares on every tick edge, and checks outputs hold between ticks.
  initial begin
    logic [6:0] exp_v;
    logic [6:0] hold_v;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = '0;
      end else if (step_tick) begin
        @(posedge clk);
        #1;
        tick_no++;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tick_unexpected: got gnt=%b led=%b, expected no tick update", gnt, led);
        end else begin
          exp_v = sb_q.pop_front();
          check("tick_out", {1'b0, gnt, led}, {1'b0, exp_v});
          $display("tick %0d: req=%b gnt=%b led=%b (expected gnt=%b led=%b)",
                   tick_no, req, gnt, led, exp_v[6:4], exp_v[3:0]);
          hold_v = exp_v;
        end
      end else begin
        check("between_ticks", {1'b0, gnt, led}, {1'b0, hold_v});
      end
    end
  end

  // Tick period: 4 cycles from reset release to first tick, and between ticks.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) cnt = 0;
      else if (step_tick) begin
        check("tick_period", 8'(cnt), 8'd4);
        cnt = 1;
      end else cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    req     = 3'b000;
    req_pat = 12'h000;
    #1;
    check("reset_state", {step_tick, gnt, led}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Idle walk
    step(3'b000, 12'h000, 3'b000, 4'b0001);
    step(3'b000, 12'h000, 3'b000, 4'b0010);
    step(3'b000, 12'h000, 3'b000, 4'b0100);
    step(3'b000, 12'h000, 3'b000, 4'b1000);
    step(3'b000, 12'h000, 3'b000, 4'b0001);

    // Requester 2 drops inside hold: frozen pattern, then idle restarts walk at 0001
    step(3'b100, 12'hA00, 3'b100, 4'b1010);
    step(3'b000, 12'h500, 3'b100, 4'b1010);
    step(3'b000, 12'h500, 3'b000, 4'b0001);
    step(3'b000, 12'h000, 3'b000, 4'b0010);

    // Higher priority waits for hold, then live pattern update
    step(3'b100, 12'hA00, 3'b100, 4'b1010);
    step(3'b101, 12'hA06, 3'b100, 4'b1010);
    step(3'b101, 12'hA06, 3'b001, 4'b0110);
    step(3'b001, 12'hA06, 3'b001, 4'b0110);
    step(3'b001, 12'hA03, 3'b001, 4'b0011);
    step(3'b000, 12'hA03, 3'b000, 4'b0001);

    // Simultaneous 0 and 1; lower priority never preempts
    step(3'b011, 12'h095, 3'b001, 4'b0101);
    step(3'b011, 12'h095, 3'b001, 4'b0101);
    step(3'b011, 12'h095, 3'b001, 4'b0101);
    step(3'b010, 12'h095, 3'b010, 4'b1001);
    step(3'b110, 12'h395, 3'b010, 4'b1001);
    step(3'b110, 12'h395, 3'b010, 4'b1001);
    step(3'b000, 12'h395, 3'b000, 4'b0001);

    // Asynchronous reset mid-ownership
    step(3'b100, 12'hC00, 3'b100, 4'b1100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {step_tick, gnt, led}, 8'h00);
    sb_q.delete();
    req     = 3'b000;
    req_pat = 12'h000;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step(3'b000, 12'h000, 3'b000, 4'b0001);
    step(3'b000, 12'h000, 3'b000, 4'b0010);

    // Owner pattern 1111, then regrant to requester 0 (blink phase restarts)
    step(3'b010, 12'h0F0, 3'b010, 4'b1111);
    step(3'b010, 12'h0F0, 3'b010, BLINK ? 4'b0000 : 4'b1111);
    step(3'b010, 12'h0F0, 3'b010, 4'b1111);
    step(3'b011, 12'h0F3, 3'b001, 4'b0011);
    step(3'b001, 12'h0F3, 3'b001, BLINK ? 4'b0000 : 4'b0011);
    step(3'b000, 12'h0F3, 3'b000, 4'b0001);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_scheduler.md
Name: led_pattern_scheduler

Overview:
Shares the 4-bit board LED bank between three requesters (e.g. fault, status, heartbeat) under fixed priority. Generates its own step tick from the system clock and only updates the LEDs or changes ownership on step ticks. Shows a built-in walking-one idle pattern when nobody owns the bank. Sits between the requesting logic and the LED pins, in place of a free-running blinker.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
STEP_HZ, 2, step tick rate in Hz. DIV = CLK_HZ/STEP_HZ, which must be ≥ 2.
MIN_HOLD_STEPS, 4, minimum ticks an owner keeps the LEDs once granted. Must be ≥ 1.

Ports:
clk  in  1  system clock; all state is on the rising edge.
rst  in  1  asynchronous active-high reset.
req  in  3  per-requester request; req[0] is highest priority.
req_pat  in  12  patterns; req_pat[4k+3:4k] belongs to requester k.
gnt  out  3  registered one-hot owner, or 000 when idle.
led  out  4  registered LED drive.
step_tick  out  1  one-cycle pulse every DIV clocks.

Behaviour:
- Reset (asynchronous, immediate): led=0000, gnt=000, step_tick=0, state=IDLE, prescaler=0, walk_idx=0, hold_cnt=0, pattern latch=0000.
- Prescaler:
  - Width clog2(DIV). Counts 0..DIV-1 and wraps.
  - step_tick is registered and is 1 in the cycle after the count reaches DIV-1.
  - The first tick occurs DIV cycles after rst deasserts.
- All state, led and gnt updates below happen only on clock edges where step_tick=1. Between ticks, every output is held.
- Arbitration: winner = lowest-indexed asserted req bit, sampled on the tick edge.
- IDLE state:
  - If req==000: led <= 0001 << walk_idx, then walk_idx <= walk_idx+1 (wraps 3→0).
  - Otherwise: gnt <= onehot(winner); latch <= req_pat[winner]; led <= req_pat[winner]; hold_cnt <= 0; go to OWN.
- OWN state, owner k, on each tick:
  - If hold_cnt < MIN_HOLD_STEPS-1: hold_cnt increments and there is no release.
  - Else (hold satisfied) release is evaluated:
    - If req[k]=0, or some req[j] with j<k is asserted, and req != 000: regrant to the winner, reload latch/led from its pattern, hold_cnt <= 0. A self-regrant is impossible here.
    - If req==000: go to IDLE, gnt <= 000, walk_idx <= 1, led <= 0001.
    - Otherwise: stay OWN.
  - While staying OWN: if req[k]=1, latch <= req_pat[k] (live update each tick); if req[k]=0 the latch stays frozen. led <= latch value being written.
- A lower-priority request never preempts. A higher-priority request waits until the hold is satisfied.
- A requester dropping req before the hold expires still owns the bank until the hold expires.
- Patterns are sampled only on ticks. Pattern changes between ticks are invisible.

Optional Feature:
LED_PATTERN_SCHEDULER_BLINK_EN:
- Defined: a phase flop (reset 1, set to 1 on every grant or regrant, toggled on every OWN tick otherwise) gates led in OWN. led = phase ? latch : 0000. IDLE is unaffected.
- Undefined: no phase flop; the OWN pattern is steady.

Test Plan:
All scenarios use CLK_HZ=8, STEP_HZ=2 (DIV=4), MIN_HOLD_STEPS=2, macro undefined unless stated.
1. Reset, then req=000 → led=0000 and gnt=000 until the first tick (cycle 4 after release), then led 0001,0010,0100,1000,0001 on successive ticks. step_tick high exactly one cycle in every 4.
2. req=100, pat2=1010 before a tick → on that tick gnt=100, led=1010. Drop req right after → led stays 1010 one more tick, then IDLE with led=0001, gnt=000.
3. Requester 2 owns (pat 1010). Raise req[0] (pat 0110) one cycle after the grant tick → next tick unchanged (hold not met). On the following tick gnt=001, led=0110.
4. req=011 simultaneously from IDLE → gnt=001, led=pat0. Requester 1 gets gnt=010 only after req[0] drops and the hold is satisfied.
5. Assert rst mid-OWN, between ticks → led=0000 and gnt=000 immediately, without waiting for a clock edge. After release the walk restarts at 0001 on the first tick.
6. Macro defined, requester 1 owns with pat 1111 → led on successive OWN ticks 1111,0000,1111,…. Phase restarts at 1111 on a regrant.
